// File: rtl/music_pkg.sv
// music_pkg: note codes, divide-ratio table and sequencer state encoding
package music_pkg;

    localparam logic [3:0] REST = 4'd0;
    localparam logic [3:0] DO   = 4'd1;
    localparam logic [3:0] RE   = 4'd2;
    localparam logic [3:0] MI   = 4'd3;
    localparam logic [3:0] FA   = 4'd4;
    localparam logic [3:0] SO   = 4'd5;
    localparam logic [3:0] LA   = 4'd6;
    localparam logic [3:0] SI   = 4'd7;

    // half-period ratios for a 1 MHz tone-divider clock; unused codes stay silent
    localparam logic [15:0] DIV_TABLE [0:15] = '{
        16'd0, 16'd955, 16'd851, 16'd758, 16'd716, 16'd638, 16'd568, 16'd506,
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0
    };

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

endpackage

// File: rtl/song_rom.sv
// song_rom: melody table of {note_code, duration} entries
module song_rom
    import music_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DUR_W  = 4
)(
    input  logic [ADDR_W-1:0] addr,
    output logic [3+DUR_W:0]  data
);

    function automatic logic [3+DUR_W:0] e(input logic [3:0] c, input int d);
        return {c, DUR_W'(d)};
    endfunction

    always_comb begin
        data = e(REST, 1);
        case (int'(addr))
            0:  data = e(DO, 2);
            1:  data = e(MI, 0);
            2:  data = e(REST, 3);
            3:  data = e(SO, 1);
            4:  data = e(LA, 2);
            5:  data = e(SI, 1);
            6:  data = e(LA, 1);
            7:  data = e(SO, 2);
            8:  data = e(FA, 2);
            9:  data = e(MI, 1);
            10: data = e(RE, 1);
            11: data = e(DO, 3);
            12: data = e(REST, 1);
            13: data = e(SO, 2);
            14: data = e(RE, 2);
            15: data = e(DO, 4);
            default: data = e(REST, 1);
        endcase
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks the song ROM, loading each note's divide ratio and
// gating the tone divider for the note's duration in beat ticks
module note_sequencer
    import music_pkg::*;
#(
    parameter int F_DIV_WIDTH = 10,
    parameter int SONG_LEN    = 16,
    parameter int ADDR_W      = 4,
    parameter int DUR_W       = 4,
    parameter int TEMPO_DIV   = 1000,
    parameter int GAP_TICKS   = 1
)(
    input  logic                   clockin,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    output logic [F_DIV_WIDTH-1:0] f_div,
    output logic                   tone_en,
    output logic [ADDR_W-1:0]      note_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int BW = $clog2(TEMPO_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int CW = (DUR_W > GW) ? DUR_W : GW;

    state_t             state, nxt, step;
    logic [BW-1:0]      beat_cnt;
    logic [CW-1:0]      cnt;
    logic               start_low;
    logic [3+DUR_W:0]   rom_data;
    logic [3:0]         code;
    logic [DUR_W-1:0]   dur;
    logic               tick, fin, adv, last, start_edge;

    song_rom #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) u_rom (
        .addr (note_idx),
        .data (rom_data)
    );

    assign code       = rom_data[3+DUR_W -: 4];
    assign dur        = rom_data[DUR_W-1:0];
    // start_low resets to 0 so a start held high through reset is not an edge
    assign start_edge = start & start_low;
    assign tick       = (state inside {PLAY, GAP}) && beat_cnt == BW'(TEMPO_DIV - 1);
    assign fin        = tick && cnt == CW'(1);
    assign adv        = fin && (state == GAP || (state == PLAY && GAP_TICKS == 0));
    assign last       = note_idx == ADDR_W'(SONG_LEN - 1);
    assign step       = (last && !loop_en) ? DONE : LOAD;
    assign busy       = state inside {LOAD, PLAY, GAP};
    assign done       = state == DONE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_edge ? LOAD : IDLE;
            LOAD:    nxt = PLAY;
            PLAY:    nxt = fin ? ((GAP_TICKS > 0) ? GAP : step) : PLAY;
            GAP:     nxt = fin ? step : GAP;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (stop) nxt = IDLE;
    end

    always_ff @(posedge clockin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            cnt       <= '0;
            start_low <= 1'b0;
            f_div     <= '0;
            tone_en   <= 1'b0;
            note_idx  <= '0;
        end else begin
            state     <= nxt;
            start_low <= ~start;
            beat_cnt  <= (tick || !(state inside {PLAY, GAP})) ? '0 : beat_cnt + 1'b1;
            if (state == LOAD) cnt <= (dur == '0) ? CW'(1) : CW'(dur);
            else if (fin && state == PLAY) cnt <= CW'(GAP_TICKS);
            else if (tick) cnt <= cnt - 1'b1;
            if (nxt == IDLE || nxt == DONE) begin
                tone_en <= 1'b0;
                f_div   <= '0;
            end else if (state == LOAD) begin
                tone_en <= code != REST;
                f_div   <= F_DIV_WIDTH'(DIV_TABLE[code]);
            end else if (fin) begin
                tone_en <= 1'b0;
            end
            if (nxt == IDLE) note_idx <= '0;
            else if (adv && nxt == LOAD) note_idx <= last ? '0 : note_idx + 1'b1;
        end
    end

endmodule
